// File: rtl/multicycle_controller_pkg.sv
// mips_ctrl_pkg: opcodes, functs, FSM states and select encodings
// shared by the multicycle controller, its decoder and interface.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_OP7  = 6'b000111;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_JUMP  = 2'b01;
  localparam logic [1:0] PC_RS    = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b11;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_LINK = 2'b10;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_OP7 = 2'b11;

  localparam logic [1:0] AS_ALU  = 2'b00;
  localparam logic [1:0] AS_ADDI = 2'b01;
  localparam logic [1:0] AS_SLT  = 2'b10;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [1:0] alu_ctr;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_sel;
    logic       addi_sel;
  } sel_t;

  typedef struct packed {
    logic rtype;
    logic imm;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic link;
    logic jr;
    logic addi;
    logic illegal;
  } cls_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields, flags, ready strobes in;
// write enables, select lines, retire and debug state out.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       imem_ready;
  logic       dmem_ready;
  logic       PCWr;
  logic       IRWr;
  logic       RegWrite;
  logic       MemWrite;
  logic       nPC_sel;
  logic [1:0] pc_sel;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       ALUSrc;
  logic [1:0] Ext_Op;
  logic [1:0] ALUctr;
  logic [1:0] alu_sel;
  logic       addi_sel;
  logic       retire;
  logic [2:0] state;

  modport master (
    input  opcode, funct, zero, overflow,
    input  imem_ready, dmem_ready,
    output PCWr, IRWr, RegWrite, MemWrite,
    output nPC_sel, pc_sel, RegDst, MemtoReg,
    output ALUSrc, Ext_Op, ALUctr, alu_sel,
    output addi_sel, retire, state
  );

  modport slave (
    output opcode, funct, zero, overflow,
    output imem_ready, dmem_ready,
    input  PCWr, IRWr, RegWrite, MemWrite,
    input  nPC_sel, pc_sel, RegDst, MemtoReg,
    input  ALUSrc, Ext_Op, ALUctr, alu_sel,
    input  addi_sel, retire, state
  );
endinterface

// File: rtl/multicycle_controller_main_decoder.sv
// main_decoder: i_opcode/i_funct -> o_sel (datapath selects)
// and o_cls (instruction class flags). Purely combinational.
module main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output sel_t       o_sel,
  output cls_t       o_cls
);

  always_comb begin
    o_sel = '0;
    o_cls = '0;
    unique case (1'b1)
      (i_opcode == OP_RTYPE): begin
        case (i_funct)
          F_ADDU: begin
            o_cls.rtype   = 1'b1;
            o_sel.reg_dst = RD_RD;
            o_sel.alu_ctr = ALU_ADD;
          end
          F_SUBU: begin
            o_cls.rtype   = 1'b1;
            o_sel.reg_dst = RD_RD;
            o_sel.alu_ctr = ALU_SUB;
          end
          F_SLT: begin
            o_cls.rtype   = 1'b1;
            o_sel.reg_dst = RD_RD;
            o_sel.alu_ctr = ALU_SUB;
            o_sel.alu_sel = AS_SLT;
          end
          F_OP7: begin
            o_cls.rtype   = 1'b1;
            o_sel.reg_dst = RD_RD;
            o_sel.alu_ctr = ALU_OP7;
          end
          F_JR:    o_cls.jr      = 1'b1;
          default: o_cls.illegal = 1'b1;
        endcase
      end
      (i_opcode == OP_ORI): begin
        o_cls.imm     = 1'b1;
        o_sel.alu_src = 1'b1;
        o_sel.ext_op  = EXT_ZERO;
        o_sel.alu_ctr = ALU_OR;
      end
      (i_opcode == OP_LUI): begin
        o_cls.imm     = 1'b1;
        o_sel.alu_src = 1'b1;
        o_sel.ext_op  = EXT_UPPER;
        o_sel.alu_ctr = ALU_OR;
      end
      (i_opcode == OP_ADDI): begin
        o_cls.imm      = 1'b1;
        o_cls.addi     = 1'b1;
        o_sel.alu_src  = 1'b1;
        o_sel.ext_op   = EXT_SIGN;
        o_sel.alu_sel  = AS_ADDI;
        o_sel.addi_sel = 1'b1;
      end
      (i_opcode == OP_ADDIU): begin
        o_cls.imm     = 1'b1;
        o_sel.alu_src = 1'b1;
        o_sel.ext_op  = EXT_SIGN;
      end
      (i_opcode == OP_LW): begin
        o_cls.load       = 1'b1;
        o_sel.alu_src    = 1'b1;
        o_sel.ext_op     = EXT_SIGN;
        o_sel.mem_to_reg = M2R_MEM;
      end
      (i_opcode == OP_SW): begin
        o_cls.store   = 1'b1;
        o_sel.alu_src = 1'b1;
        o_sel.ext_op  = EXT_SIGN;
      end
      (i_opcode == OP_BEQ): begin
        o_cls.branch  = 1'b1;
        o_sel.ext_op  = EXT_SIGN;
        o_sel.alu_ctr = ALU_SUB;
      end
      (i_opcode == OP_J): o_cls.jump = 1'b1;
      (i_opcode == OP_JAL): begin
        o_cls.jump       = 1'b1;
        o_cls.link       = 1'b1;
        o_sel.reg_dst    = RD_RA;
        o_sel.mem_to_reg = M2R_LINK;
      end
      default: o_cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: IF/ID/EX/MEM/WB FSM over a shared datapath.
// Ports: clk, reset (sync, high), bus (multicycle_controller_if.master).
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_e     r_state;
  state_e     w_next;
  sel_t       w_sel;
  cls_t       w_cls;
  logic       w_pcwr;
  logic       w_irwr;
  logic       w_regwr;
  logic       w_memwr;
  logic       w_npc;
  logic [1:0] w_pcsel;
  logic       w_retire;

  main_decoder u_dec (
    .i_opcode (bus.opcode),
    .i_funct  (bus.funct),
    .o_sel    (w_sel),
    .o_cls    (w_cls)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IF;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_pcwr  = 1'b0;
    w_irwr  = 1'b0;
    w_regwr = 1'b0;
    w_memwr = 1'b0;
    w_npc   = 1'b0;
    w_pcsel = PC_PLUS4;
    unique case (r_state)
      S_IF: begin
        w_irwr = bus.imem_ready;
        w_pcwr = bus.imem_ready;
        if (bus.imem_ready) w_next = S_ID;
      end
      S_ID: begin
        if (w_cls.illegal) begin
          w_next = S_IF;
        end else if (w_cls.jump) begin
          w_pcwr  = 1'b1;
          w_pcsel = PC_JUMP;
          w_regwr = w_cls.link;
          w_next  = S_IF;
        end else if (w_cls.jr) begin
          w_pcwr  = 1'b1;
          w_pcsel = PC_RS;
          w_next  = S_IF;
        end else if (w_cls.rtype | w_cls.imm | w_cls.load |
                     w_cls.store | w_cls.branch) begin
          w_next = S_EX;
        end else begin
          w_next = S_IF;
        end
      end
      S_EX: begin
        if (w_cls.branch) begin
          w_npc  = 1'b1;
          w_pcwr = bus.zero;
          w_next = S_IF;
        end else if (w_cls.load | w_cls.store) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_memwr = w_cls.store;
        if (bus.dmem_ready)
          w_next = w_cls.store ? S_IF : S_WB;
      end
      S_WB: begin
        w_regwr = w_cls.addi ? ~bus.overflow : 1'b1;
        w_next  = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

  assign w_retire = (r_state != S_IF) && (w_next == S_IF);

  // Reset masks enables combinationally so a write in flight in the
  // reset cycle never lands.
  assign bus.PCWr     = w_pcwr   & ~reset;
  assign bus.IRWr     = w_irwr   & ~reset;
  assign bus.RegWrite = w_regwr  & ~reset;
  assign bus.MemWrite = w_memwr  & ~reset;
  assign bus.nPC_sel  = w_npc    & ~reset;
  assign bus.pc_sel   = reset ? PC_PLUS4 : w_pcsel;
  assign bus.retire   = w_retire & ~reset;
  assign bus.state    = reset ? S_IF : r_state;

  assign bus.RegDst   = w_sel.reg_dst;
  assign bus.ALUSrc   = w_sel.alu_src;
  assign bus.Ext_Op   = w_sel.ext_op;
  assign bus.ALUctr   = w_sel.alu_ctr;
  assign bus.MemtoReg = w_sel.mem_to_reg;
  assign bus.alu_sel  = w_sel.alu_sel;
  assign bus.addi_sel = w_sel.addi_sel;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state and
// enable vectors against hand-computed tables.
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWr,IRWr,RegWrite,MemWrite,nPC_sel,pc_sel,retire}
  wire [7:0] en = {bus.PCWr, bus.IRWr, bus.RegWrite,
                   bus.MemWrite, bus.nPC_sel, bus.pc_sel,
                   bus.retire};
  // {RegDst,ALUSrc,Ext_Op,ALUctr,MemtoReg,alu_sel,addi_sel}
  wire [11:0] sel = {bus.RegDst, bus.ALUSrc, bus.Ext_Op,
                     bus.ALUctr, bus.MemtoReg, bus.alu_sel,
                     bus.addi_sel};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] st [4];
    st = '{0, 1, 2, 3};
    reset = 1'b1;
    bus.opcode = OP_LW; bus.funct = 6'd0;
    bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
    bus.zero = 1'b0; bus.overflow = 1'b0;
    tick(); tick();
    #1;
    total++;
    if (bus.state !== 3'd0 || en !== 8'h00)
      $display("FAIL rst_hold state=%0d en=%h want 0/00",
               bus.state, en);
    else passed++;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (bus.state !== st[c])
        $display("FAIL rst_lw c%0d state=%0d want %0d",
                 c, bus.state, st[c]);
      else passed++;
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      reset = 1'b1;
      #1;
      total++;
      if (bus.state !== 3'd0 || en !== 8'h00)
        $display("FAIL rst_mid c%0d state=%0d en=%h want 0/00",
                 c, bus.state, en);
      else passed++;
      tick();
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.state !== 3'd0 || en !== 8'hC0)
      $display("FAIL rst_release state=%0d en=%h want 0/c0",
               bus.state, en);
    else passed++;
    bus.opcode = OP_J;
    tick();
    #1;
    total++;
    if (bus.state !== 3'd1 || en !== 8'h83)
      $display("FAIL rst_j state=%0d en=%h want 1/83",
               bus.state, en);
    else passed++;
    tick();
  endtask

  task automatic test_addu();
    logic [2:0] st [4];
    logic [7:0] ev [4];
    st = '{0, 1, 2, 4};
    ev = '{8'hC0, 8'h00, 8'h00, 8'h21};
    bus.opcode = OP_RTYPE; bus.funct = F_ADDU;
    bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (bus.state !== st[c] || en !== ev[c])
        $display("FAIL addu c%0d state=%0d en=%h want %0d/%h",
                 c, bus.state, en, st[c], ev[c]);
      else passed++;
      total++;
      if (bus.RegDst !== RD_RD)
        $display("FAIL addu_regdst c%0d got %b want 01",
                 c, bus.RegDst);
      else passed++;
      tick();
    end
    total++;
    if (bus.state !== 3'd0)
      $display("FAIL addu_end state=%0d want 0", bus.state);
    else passed++;
  endtask

  task automatic test_lw_stall();
    logic [2:0] st [7];
    logic [7:0] ev [7];
    logic       dr [7];
    st = '{0, 1, 2, 3, 3, 3, 4};
    ev = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h21};
    dr = '{1, 1, 1, 0, 0, 1, 0};
    bus.opcode = OP_LW; bus.funct = 6'd0;
    bus.imem_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.dmem_ready = dr[c];
      #1;
      total++;
      if (bus.state !== st[c] || en !== ev[c] ||
          bus.MemtoReg !== M2R_MEM)
        $display("FAIL lw c%0d state=%0d en=%h m2r=%b want %0d/%h/01",
                 c, bus.state, en, bus.MemtoReg, st[c], ev[c]);
      else passed++;
      tick();
    end
    bus.dmem_ready = 1'b1;
  endtask

  task automatic test_sw_fetch_stall();
    logic [2:0] st [5];
    logic [7:0] ev [5];
    logic       ir [5];
    st = '{0, 0, 1, 2, 3};
    ev = '{8'h00, 8'hC0, 8'h00, 8'h00, 8'h11};
    ir = '{0, 1, 0, 1, 1};
    bus.opcode = OP_SW; bus.dmem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.imem_ready = ir[c];
      #1;
      total++;
      if (bus.state !== st[c] || en !== ev[c])
        $display("FAIL sw c%0d state=%0d en=%h want %0d/%h",
                 c, bus.state, en, st[c], ev[c]);
      else passed++;
      tick();
    end
    bus.imem_ready = 1'b1;
  endtask

  task automatic test_beq();
    logic [7:0] ev [2][3];
    ev = '{'{8'hC0, 8'h00, 8'h89}, '{8'hC0, 8'h00, 8'h09}};
    bus.opcode = OP_BEQ;
    for (int k = 0; k < 2; k++) begin
      bus.zero = (k == 0);
      for (int c = 0; c < 3; c++) begin
        #1;
        total++;
        if (bus.state !== 3'(c) || en !== ev[k][c])
          $display("FAIL beq z%0d c%0d state=%0d en=%h want %0d/%h",
                   1 - k, c, bus.state, en, c, ev[k][c]);
        else passed++;
        tick();
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_addi();
    logic [2:0] st [4];
    logic [7:0] ev [2][4];
    st = '{0, 1, 2, 4};
    ev = '{'{8'hC0, 8'h00, 8'h00, 8'h01},
           '{8'hC0, 8'h00, 8'h00, 8'h21}};
    bus.opcode = OP_ADDI;
    for (int k = 0; k < 2; k++) begin
      bus.overflow = (k == 0);
      for (int c = 0; c < 4; c++) begin
        #1;
        total++;
        if (bus.state !== st[c] || en !== ev[k][c] ||
            bus.alu_sel !== AS_ADDI || bus.addi_sel !== 1'b1)
          $display("FAIL addi ov%0d c%0d st=%0d en=%h as=%b a=%b want %0d/%h/01/1",
                   1 - k, c, bus.state, en, bus.alu_sel,
                   bus.addi_sel, st[c], ev[k][c]);
        else passed++;
        tick();
      end
    end
    bus.overflow = 1'b0;
  endtask

  task automatic test_jumps();
    logic [5:0] op [4];
    logic [5:0] fn [4];
    logic [7:0] ev [4];
    op = '{OP_JAL, 6'b111111, OP_J, OP_RTYPE};
    fn = '{6'd0, 6'd0, 6'd0, F_JR};
    ev = '{8'hA3, 8'h01, 8'h83, 8'h85};
    for (int k = 0; k < 4; k++) begin
      bus.opcode = op[k]; bus.funct = fn[k];
      #1;
      total++;
      if (bus.state !== 3'd0 || en !== 8'hC0)
        $display("FAIL jmp%0d_if state=%0d en=%h want 0/c0",
                 k, bus.state, en);
      else passed++;
      tick();
      total++;
      if (bus.state !== 3'd1 || en !== ev[k])
        $display("FAIL jmp%0d_id state=%0d en=%h want 1/%h",
                 k, bus.state, en, ev[k]);
      else passed++;
      if (k == 0) begin
        total++;
        if (bus.RegDst !== RD_RA || bus.MemtoReg !== M2R_LINK)
          $display("FAIL jal_sel regdst=%b m2r=%b want 11/10",
                   bus.RegDst, bus.MemtoReg);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_selects();
    logic [5:0]  op [9];
    logic [5:0]  fn [9];
    logic [11:0] ex [9];
    op = '{OP_ORI, OP_LUI, OP_RTYPE, OP_RTYPE, OP_RTYPE,
           OP_SW, OP_ADDIU, 6'b111111, OP_RTYPE};
    fn = '{6'd0, 6'd0, F_SLT, F_OP7, F_SUBU,
           6'd0, 6'd0, 6'd0, 6'b111111};
    ex = '{12'b00_1_00_10_00_00_0, 12'b00_1_10_10_00_00_0,
           12'b01_0_00_01_00_10_0, 12'b01_0_00_11_00_00_0,
           12'b01_0_00_01_00_00_0, 12'b00_1_01_00_00_00_0,
           12'b00_1_01_00_00_00_0, 12'b00_0_00_00_00_00_0,
           12'b00_0_00_00_00_00_0};
    bus.imem_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.opcode = op[k]; bus.funct = fn[k];
      #1;
      total++;
      if (sel !== ex[k] || bus.state !== 3'd0 || en !== 8'h00)
        $display("FAIL sel%0d sel=%b st=%0d en=%h want %b/0/00",
                 k, sel, bus.state, en, ex[k]);
      else passed++;
      tick();
    end
    bus.imem_ready = 1'b1;
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_addu();
    test_lw_stall();
    test_sw_fetch_stall();
    test_beq();
    test_addi();
    test_jumps();
    test_selects();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control unit for the MIPS-subset CPU: a five-state FSM that sequences one shared datapath (PC, IR, register file, ALU, data memory) over IF/ID/EX/MEM/WB cycles instead of one single-cycle decode. It reads opcode/funct from the datapath IR and drives per-state write enables plus the datapath select lines. Instruction and data memory may stall through ready inputs; unknown instructions retire as no-ops.

## Interface
- No parameters.
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], valid from ID onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU equal flag (beq)
- overflow  in  1  ALU signed-overflow flag (addi)
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access completes this cycle
- PCWr, IRWr, RegWrite, MemWrite  out  1 each  write enables
- nPC_sel  out  1  branch target select
- pc_sel  out  2  00 PC+4, 01 jump target, 10 rs (jr)
- RegDst  out  2  00 rt, 01 rd, 11 $31
- MemtoReg  out  2  00 ALU, 01 memory, 10 PC+4 (link)
- ALUSrc  out  1  0 rt, 1 extended imm
- Ext_Op  out  2  00 zero, 01 sign, 10 upper (lui)
- ALUctr  out  2  00 add, 01 sub, 10 or, 11 funct 000111 op
- alu_sel  out  2  00 ALU, 01 addi path, 10 slt
- addi_sel  out  1  addi overflow check active
- retire  out  1  one-cycle pulse when an instruction completes
- state  out  3  current FSM state (debug)

## Operation
- Supported: addu, subu, slt, jr, funct 000111 (R-type); ori, lw, sw, beq, lui, j, addi, addiu, jal.
- States: IF=0, ID=1, EX=2, MEM=3, WB=4.
- IF: IRWr=PCWr=imem_ready, pc_sel=00; stay while !imem_ready; else -> ID.
- ID: j: PCWr=1, pc_sel=01 -> IF. jal: also RegWrite=1, RegDst=11, MemtoReg=10 -> IF. jr: PCWr=1, pc_sel=10 -> IF. Unknown opcode/funct: no enables -> IF. Others -> EX.
- EX: beq: nPC_sel=1, PCWr=zero, ALUctr=01 -> IF. lw/sw -> MEM. All else -> WB.
- MEM: sw: MemWrite=1; wait for dmem_ready then -> IF. lw: wait for dmem_ready -> WB.
- WB: RegWrite=1 with selects per instruction; addi: RegWrite=!overflow -> IF.
- Select lines (RegDst, ALUSrc, Ext_Op, ALUctr, MemtoReg, alu_sel, addi_sel) are a pure function of opcode/funct, held constant in every state; don't-cares drive 0, never x.
- Write enables are a function of state and instruction only; zero in any state not listed above.
- retire=1 on every transition into IF from another state, including unknown-instruction and overflow-suppressed addi.

## Timing
- Reset: state=IF; all enables, nPC_sel, pc_sel, retire = 0 while reset high; first fetch enable one cycle after reset release.
- Reset mid-instruction: abort at the next edge; no partial write occurs after reset is sampled.
- Latency at zero wait: j/jal/jr/unknown 2 cycles; beq 3; R-type/imm 4; sw 4; lw 5. Each ready-low cycle adds one.
- Outputs combinational from state register and inputs; no output register.
- zero/overflow sampled combinationally in EX/WB only; ignored elsewhere.
- Ready low in any non-wait state has no effect.

## Structure
- Package mips_ctrl_pkg: opcode/funct constants, state enum, encodings for pc_sel, RegDst, MemtoReg, Ext_Op, ALUctr, alu_sel.
- Sub-module main_decoder: combinational opcode/funct -> select lines plus instruction-class flags (rtype, load, store, branch, jump, link, jr, illegal); multicycle_controller holds the FSM and enable logic.

## Test plan
- Reset held 3 cycles mid-lw MEM wait -> state=0, all enables 0; IRWr=1 on first cycle after release with imem_ready=1.
- addu (op 0, funct 100001), ready always 1 -> states 0,1,2,4,0; RegWrite=1 only in WB, RegDst=01; retire pulse after cycle 4.
- lw with dmem_ready low 2 cycles -> MEM held 3 cycles, MemtoReg=01, RegWrite only in WB; total 7 cycles.
- beq with zero=1 then zero=0 -> PCWr=1, nPC_sel=1 in EX first case; PCWr=0 second; both 3 cycles.
- addi with overflow=1 -> RegWrite=0 in WB, alu_sel=01, addi_sel=1, retire still pulses; overflow=0 -> RegWrite=1.
- jal then opcode 111111 -> jal: ID PCWr=1, RegWrite=1, RegDst=11, MemtoReg=10; illegal: 2 cycles, no enables, retire=1.
